// File: rtl/afifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : afifo_wr_arbiter_if
//  Purpose  : Bundles the requester handshakes and the async-FIFO write port
//             that the write arbiter sits between.
//  Signals  : req_valid/req_last/req_data  - per-requester beat offer
//             req_ready                    - per-requester beat accepted
//             wfull                        - FIFO full (write domain)
//             wpush/wdata                  - FIFO write strobe and data
//             grant_id/busy                - current owner and lock status
//  Modports : master - the arbiter (drives the FIFO write port)
//             slave  - the requesters/FIFO side facing the arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface afifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wfull;
  logic               wpush;
  logic [DW-1:0]      wdata;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, wpush, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, wpush, wdata, grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/afifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : afifo_wr_arbiter
//  Purpose  : Round-robin, packet-locked arbiter sharing the single write port
//             of an asynchronous FIFO among NREQ write-domain requesters.
//             A grant is held from the first beat until the beat flagged
//             last, so packets never interleave in the FIFO.
//  Ports    : wclk - write-domain clock (rising edge)
//             wrst - synchronous active-high reset
//             bus  - afifo_wr_arbiter_if.master (requesters + FIFO write port)
//  Revision : 1.0  initial release
// ============================================================================
module afifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = 2
) (
  input wire logic              wclk,
  input wire logic              wrst,
  afifo_wr_arbiter_if.master    bus
);

  // One extra bit so pointer + offset never overflows before the modulo fold.
  localparam int c_sum_w = IDW + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;

  logic [2*NREQ-1:0] w_valid_dbl;
  logic [NREQ-1:0]   w_valid_rot;
  logic              w_win_found;
  logic [c_sum_w-1:0] w_win_off;
  logic [c_sum_w-1:0] w_win_sum;
  logic [IDW-1:0]    w_win_id;

  logic              w_own_valid;
  logic              w_own_last;
  logic [DW-1:0]     w_own_data;

  logic              w_acc;
  logic [NREQ-1:0]   w_ready;
  logic [DW-1:0]     w_wdata;

  // --------------------------------------------------------------------------
  // Round-robin search: rotate req_valid so that bit 0 is the requester at
  // rr_ptr, take the first set bit, then map the offset back to an index.
  // --------------------------------------------------------------------------
  assign w_valid_dbl = {bus.req_valid, bus.req_valid};
  assign w_valid_rot = NREQ'(w_valid_dbl >> rr_ptr_q);

  always_comb begin
    w_win_found = 1'b0;
    w_win_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_win_found && w_valid_rot[k]) begin
        w_win_found = 1'b1;
        w_win_off   = c_sum_w'(k);
      end
    end
    w_win_sum = {1'b0, rr_ptr_q} + w_win_off;
    if (w_win_sum >= c_sum_w'(NREQ)) begin
      w_win_id = IDW'(w_win_sum - c_sum_w'(NREQ));
    end else begin
      w_win_id = w_win_sum[IDW-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Owner select: compare-based mux avoids indexing with an IDW-wide value
  // when NREQ is not a power of two.
  // --------------------------------------------------------------------------
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        w_own_valid = bus.req_valid[i];
        w_own_last  = bus.req_last[i];
        w_own_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. The IDLE cycle only arbitrates, which gives the
  // one-cycle bubble between packets; all write-port outputs are low there.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    w_acc      = 1'b0;
    w_ready    = '0;
    w_wdata    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // wfull is deliberately ignored here: arbitration proceeds and the
        // owner simply waits in LOCK until space appears.
        if (w_win_found) begin
          grant_id_d = w_win_id;
          state_d    = ST_LOCK;
        end
      end

      ST_LOCK: begin
        w_acc   = w_own_valid & ~bus.wfull;
        w_wdata = w_own_data;
        for (int i = 0; i < NREQ; i++) begin
          w_ready[i] = w_acc && (grant_id_q == IDW'(i));
        end
        // The lock is released only by an accepted last beat; an owner that
        // stalls mid-packet keeps the port indefinitely.
        if (w_acc && w_own_last) begin
          state_d = ST_IDLE;
          if (grant_id_q == IDW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_id_q + IDW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.wpush     = w_acc;
  assign bus.req_ready = w_ready;
  assign bus.wdata     = w_wdata;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q == ST_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_afifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_afifo_wr_arbiter
//  Purpose  : Self-checking bench for afifo_wr_arbiter (NREQ=4 and NREQ=3).
//             Requester beats are queued per source; every beat loaded is
//             also pushed to an expected-order scoreboard that a FIFO-side
//             monitor pops on each wpush.
//  Revision : 1.0  initial release
// ============================================================================
module tb_afifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  afifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();
  afifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  afifo_wr_arbiter_if #(.NREQ(3), .DW(DW), .IDW(2)) bus3 ();
  afifo_wr_arbiter #(.NREQ(3), .DW(DW), .IDW(2)) dut3 (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus3)
  );

  typedef struct {
    int            id;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic            wfull;
    logic            busy;
    logic [IDW-1:0]  gid;
    logic            wpush;
    logic [NREQ-1:0] ready;
    logic [DW-1:0]   wdata;
  } row_t;

  beat_t bq[$];   // beats still held by the requesters
  beat_t sb[$];   // expected FIFO write order

  int errors = 0;
  int checks = 0;

  logic            rst_v;
  logic            wfull_v;
  logic [NREQ-1:0] en_v;
  logic [NREQ-1:0] acc_seen;

  logic            s_busy;
  logic            s_wpush;
  logic [IDW-1:0]  s_gid;
  logic [NREQ-1:0] s_ready;
  logic [DW-1:0]   s_wdata;

  row_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic wf, input logic busy, input logic [IDW-1:0] gid,
                              input logic wp, input logic [NREQ-1:0] rdy, input logic [DW-1:0] wd);
    row_t r;
    r.wfull = wf; r.busy = busy; r.gid = gid; r.wpush = wp; r.ready = rdy; r.wdata = wd;
    return r;
  endfunction

  task automatic load(input int r, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.id   = r;
      b.last = (k == n - 1);
      b.data = base + DW'(k);
      bq.push_back(b);
      sb.push_back(b);
    end
  endtask

  // Retire beats accepted at the last edge, then present each requester's
  // oldest remaining beat.
  task automatic drive();
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    l;
    logic [NREQ*DW-1:0] d;
    bit                 found;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_seen[i]) begin
        found = 0;
        for (int j = 0; j < bq.size(); j++) begin
          if (!found && bq[j].id == i) begin
            found = 1;
            bq.delete(j);
          end
        end
      end
    end
    acc_seen = '0;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      found = 0;
      for (int j = 0; j < bq.size(); j++) begin
        if (!found && bq[j].id == i) begin
          found = 1;
          if (en_v[i]) begin
            v[i] = 1'b1;
            l[i] = bq[j].last;
            d[i*DW +: DW] = bq[j].data;
          end
        end
      end
    end
    wrst          = rst_v;
    bus.wfull     = wfull_v;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
    drive();
    #3;
    s_busy   = bus.busy;
    s_wpush  = bus.wpush;
    s_gid    = bus.grant_id;
    s_ready  = bus.req_ready;
    s_wdata  = bus.wdata;
    acc_seen = bus.req_ready;
  endtask

  task automatic run_rows(input int lo, input int hi, input string tag);
    for (int r = lo; r <= hi; r++) begin
      wfull_v = tbl[r].wfull;
      tick();
      check($sformatf("%s_r%0d_busy", tag, r), s_busy, tbl[r].busy);
      check($sformatf("%s_r%0d_gid", tag, r), s_gid, tbl[r].gid);
      check($sformatf("%s_r%0d_wpush", tag, r), s_wpush, tbl[r].wpush);
      check($sformatf("%s_r%0d_ready", tag, r), s_ready, tbl[r].ready);
      if (tbl[r].wpush) check($sformatf("%s_r%0d_wdata", tag, r), s_wdata, tbl[r].wdata);
    end
    wfull_v = 1'b0;
  endtask

  // FIFO-side monitor: every push must be the next expected beat from the
  // expected owner, never while full, and ready must go only to that owner.
  always @(negedge wclk) begin
    beat_t e;
    if (bus.wfull === 1'b1) check("mon_no_push_when_full", bus.wpush, 1'b0);
    if (bus.wpush === 1'b1) begin
      if (sb.size() == 0) begin
        check("mon_unexpected_push", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("mon_wdata", bus.wdata, e.data);
        check("mon_grant_id", bus.grant_id, e.id);
        check("mon_ready_onehot", bus.req_ready, NREQ'(1) << e.id);
      end
    end else begin
      check("mon_ready_without_push", bus.req_ready, '0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wrst = 1'b1; rst_v = 1'b1; wfull_v = 1'b0; en_v = '1; acc_seen = '0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.wfull = 1'b0;
    bus3.req_valid = '0; bus3.req_last = '0; bus3.req_data = '0; bus3.wfull = 1'b0;

    // Test 1: single 3-beat packet from requester 2
    tbl[0]  = mk(0, 0, 0, 0, 4'b0000, 32'h0);
    tbl[1]  = mk(0, 1, 2, 1, 4'b0100, 32'hA1);
    tbl[2]  = mk(0, 1, 2, 1, 4'b0100, 32'hA2);
    tbl[3]  = mk(0, 1, 2, 1, 4'b0100, 32'hA3);
    tbl[4]  = mk(0, 0, 2, 0, 4'b0000, 32'h0);
    // Test 3: owner 1 stalled by wfull for 5 cycles mid-packet
    tbl[5]  = mk(0, 0, 3, 0, 4'b0000, 32'h0);
    tbl[6]  = mk(0, 1, 1, 1, 4'b0010, 32'hB1);
    tbl[7]  = mk(1, 1, 1, 0, 4'b0000, 32'h0);
    tbl[8]  = mk(1, 1, 1, 0, 4'b0000, 32'h0);
    tbl[9]  = mk(1, 1, 1, 0, 4'b0000, 32'h0);
    tbl[10] = mk(1, 1, 1, 0, 4'b0000, 32'h0);
    tbl[11] = mk(1, 1, 1, 0, 4'b0000, 32'h0);
    tbl[12] = mk(0, 1, 1, 1, 4'b0010, 32'hB2);
    tbl[13] = mk(0, 1, 1, 1, 4'b0010, 32'hB3);
    tbl[14] = mk(0, 0, 1, 0, 4'b0000, 32'h0);

    tick(); tick();
    rst_v = 1'b0;
    tick();
    check("reset_busy", s_busy, 1'b0);
    check("reset_gid", s_gid, 0);
    check("reset_wpush", s_wpush, 1'b0);
    check("reset_ready", s_ready, 4'b0000);

    load(2, 3, 32'hA1);
    run_rows(0, 4, "t1");

    // rr_ptr is 3 now: with 0 and 3 valid, 3 must win, then 0, then 3 again
    load(3, 1, 32'hC3); load(0, 1, 32'hC0); load(3, 1, 32'hC4);
    tick(); tick();
    check("rr_first_gid", s_gid, 3);
    tick(); tick();
    check("rr_second_gid", s_gid, 0);
    tick(); tick();
    check("rr_third_gid", s_gid, 3);
    tick();

    // Test 2: all four requesters stream single-beat packets
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        load(i, 1, 32'hD000_0000 | (r << 8) | i);
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("t2_c%0d_wpush", c), s_wpush, c % 2);
      if (c % 2 == 1) check($sformatf("t2_c%0d_gid", c), s_gid, (c / 2) % 4);
    end

    // Test 3 (table)
    load(1, 3, 32'hB1);
    run_rows(5, 14, "t3");

    // Test 4: owner 0 goes quiet for 3 cycles while requester 3 waits
    en_v = 4'b0111;
    load(0, 3, 32'hE1); load(3, 1, 32'hF1);
    tick(); check("t4_arb_busy", s_busy, 1'b0);
    tick(); check("t4_c1_gid", s_gid, 0); check("t4_c1_wpush", s_wpush, 1'b1);
    en_v = 4'b1110;
    for (int c = 2; c < 5; c++) begin
      tick();
      check($sformatf("t4_c%0d_busy", c), s_busy, 1'b1);
      check($sformatf("t4_c%0d_gid", c), s_gid, 0);
      check($sformatf("t4_c%0d_wpush", c), s_wpush, 1'b0);
    end
    en_v = 4'b1111;
    tick(); check("t4_c5_wpush", s_wpush, 1'b1); check("t4_c5_gid", s_gid, 0);
    tick(); check("t4_c6_wpush", s_wpush, 1'b1); check("t4_c6_gid", s_gid, 0);
    tick(); check("t4_c7_busy", s_busy, 1'b0);
    tick(); check("t4_c8_gid", s_gid, 3); check("t4_c8_wpush", s_wpush, 1'b1);
    tick();

    // Test 5: reset in beat 2 of a 4-beat packet. Serving requester 2 first
    // leaves rr_ptr=3, so only a real pointer reset lets requester 0 win.
    load(2, 1, 32'h5000_0001);
    repeat (3) tick();
    load(2, 4, 32'h5100_0001);
    tick(); check("t5_arb_busy", s_busy, 1'b0);
    tick(); check("t5_beat1_wpush", s_wpush, 1'b1); check("t5_beat1_gid", s_gid, 2);
    wfull_v = 1'b1; rst_v = 1'b1;
    tick(); check("t5_rst_cycle_wpush", s_wpush, 1'b0);
    wfull_v = 1'b0; rst_v = 1'b0;
    for (int j = bq.size() - 1; j >= 0; j--)
      if (bq[j].id == 2) bq.delete(j);
    sb.delete();
    acc_seen = '0;
    load(0, 1, 32'h6000_0000); load(3, 1, 32'h6000_0003);
    tick();
    check("t5_post_busy", s_busy, 1'b0);
    check("t5_post_wpush", s_wpush, 1'b0);
    check("t5_post_gid", s_gid, 0);
    tick(); check("t5_req0_wins_gid", s_gid, 0); check("t5_req0_wins_wpush", s_wpush, 1'b1);
    tick();
    tick(); check("t5_req3_next_gid", s_gid, 3);
    tick();
    check("sb_empty", sb.size(), 0);

    // Test 6: NREQ=3 instance, pointer wrap from requester 2 back to 0
    @(posedge wclk); #1;
    bus3.req_valid = 3'b100; bus3.req_last = 3'b100;
    bus3.req_data = {32'h3000_0002, 32'h0, 32'h0};
    #3; check("t6_arb_busy", bus3.busy, 1'b0);
    @(posedge wclk); #4;
    check("t6_c1_gid", bus3.grant_id, 2);
    check("t6_c1_wpush", bus3.wpush, 1'b1);
    check("t6_c1_ready", bus3.req_ready, 3'b100);
    check("t6_c1_wdata", bus3.wdata, 32'h3000_0002);
    @(posedge wclk); #1;
    bus3.req_valid = 3'b101; bus3.req_last = 3'b101;
    bus3.req_data = {32'h3100_0002, 32'h0, 32'h3100_0000};
    #3; check("t6_c2_busy", bus3.busy, 1'b0);
    @(posedge wclk); #4;
    check("t6_c3_gid", bus3.grant_id, 0);
    check("t6_c3_wpush", bus3.wpush, 1'b1);
    check("t6_c3_ready", bus3.req_ready, 3'b001);
    check("t6_c3_gid_range", (bus3.grant_id < 2'd3), 1'b1);
    @(posedge wclk); #1;
    bus3.req_valid = 3'b100; bus3.req_last = 3'b100;
    #3; check("t6_c4_busy", bus3.busy, 1'b0);
    @(posedge wclk); #4;
    check("t6_c5_gid", bus3.grant_id, 2);
    check("t6_c5_wdata", bus3.wdata, 32'h3100_0002);
    check("t6_c5_gid_range", (bus3.grant_id < 2'd3), 1'b1);
    @(posedge wclk); #1;
    bus3.req_valid = 3'b000; bus3.req_last = 3'b000;
    #3; check("t6_end_busy", bus3.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares the single write port of an asynchronous FIFO between NREQ requesters in the write clock domain. It sits directly in front of the FIFO write-pointer/full logic. It drives wpush/wdata and honours wfull, so no beat is dropped or duplicated. A grant is held for a whole packet, delimited by a last flag, so packets from different requesters never interleave in the FIFO.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, data width of each requester and of the FIFO write data
IDW, 2, width of grant_id; must satisfy 2**IDW >= NREQ

Ports:
wclk  in  1  write-domain clock; all logic is on its rising edge
wrst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester beat valid
req_last  in  NREQ  per-requester last-beat-of-packet flag, qualified by req_valid
req_data  in  NREQ*DW  packed beat data; requester i occupies bits [i*DW +: DW]
req_ready  out  NREQ  per-requester beat accepted this cycle
wfull  in  1  FIFO full flag (registered, write domain)
wpush  out  1  FIFO write enable
wdata  out  DW  FIFO write data
grant_id  out  IDW  index of the current or most recent owner
busy  out  1  high while a packet is locked

Behaviour:
- Reset (wrst=1 at a wclk edge):
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0.
  - req_ready=0, wpush=0, wdata=0 (combinational outputs are forced low while state=IDLE).
- States: IDLE, LOCK. busy=1 only in LOCK.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - On a winner: register grant_id=winner and go to LOCK. No beat is accepted in the arbitration cycle (1-cycle bubble).
  - No valid request: remain in IDLE and leave grant_id unchanged.
  - wfull does not block arbitration.
- LOCK, combinational outputs:
  - acc = req_valid[grant_id] & ~wfull.
  - wpush = acc; req_ready[grant_id] = acc; every other req_ready bit = 0.
  - wdata = req_data[grant_id]; wdata is don't-care when wpush=0 but must equal the owner's data when wpush=1.
- LOCK transitions:
  - acc & req_last[grant_id]: go to IDLE; rr_ptr = grant_id+1, wrapping to 0 after NREQ-1.
  - Otherwise: stay in LOCK.
  - The owner deasserting req_valid mid-packet keeps the lock; there is no timeout.
- Throughput: consecutive single-beat packets sustain 1 beat per 2 cycles; a burst of L beats with wfull=0 costs L+1 cycles.
- wfull:
  - wfull=1 forces wpush=0 and req_ready=0 in that cycle; the beat stays held by the requester.
  - Pushes resume the first cycle wfull=0.
  - The arbiter never asserts wpush while wfull=1.
- Fairness: the just-served requester has lowest priority at the next arbitration. Any continuously requesting source is granted within NREQ-1 packets.
- Requester rules: req_data and req_last must be stable while req_valid=1 and req_ready=0. A requester must not drop req_valid without a handshake. A violation is a requester error; the arbiter takes no recovery action.
- Reset mid-packet: the packet is abandoned and the next cycle is IDLE with rr_ptr=0. Beats already pushed remain in the FIFO; reset of the FIFO itself is owned by the FIFO.
- Unused grant_id codes (>= NREQ) are never produced.

Test Plan:
1. Reset, then req_valid=4'b0100 with a 3-beat packet (data 0xA1, 0xA2, 0xA3 with last) -> grant_id=2, busy=1 from cycle 1; wpush high cycles 1-3 with wdata 0xA1/0xA2/0xA3; IDLE at cycle 4; rr_ptr=3.
2. All four requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,1; wpush every other cycle; no req_ready asserted for a non-owner.
3. Owner 1 mid-packet with wfull driven high for 5 cycles -> wpush=0 and req_ready=0 for exactly 5 cycles; the held beat 0xB2 is pushed once on the first cycle wfull=0; no duplicate and no loss.
4. Owner 0 drops req_valid for 3 cycles mid-packet while req 3 is valid -> lock held; grant_id stays 0; req 3 is granted only after owner 0's last beat.
5. wrst pulsed during beat 2 of a 4-beat packet -> next cycle busy=0, wpush=0, grant_id=0; then with req_valid=4'b1001, requester 0 wins.
6. NREQ=3 build: requesters 0 and 2 both valid after 2 was last served -> 0 granted; rr_ptr wraps 2 -> 0 correctly; grant_id never equals 3.
